// File: rtl/instruction_dispatcher.sv
// In-order dispatcher: one hold register feeding the weight, MMU and activation units.
// Optional performance counters are built when DISPATCH_PERF_CNT_EN is defined.

package dispatcher_pkg;

  localparam int OP_CODE_WIDTH = 8;

  typedef struct packed {
    logic [OP_CODE_WIDTH-1:0] op_code;
    logic [31:0]              calc_length;
    logic [15:0]              acc_address;
    logic [23:0]              buffer_address;
  } INSTRUCTION_TYPE;

  typedef enum logic [2:0] {
    CLS_NOP     = 3'd0,
    CLS_WEIGHT  = 3'd1,
    CLS_MMU     = 3'd2,
    CLS_ACT     = 3'd3,
    CLS_SYNC    = 3'd4,
    CLS_HALT    = 3'd5,
    CLS_ILLEGAL = 3'd6
  } instr_class_t;

endpackage

module instruction_dispatcher
  import dispatcher_pkg::*;
#(
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  INSTRUCTION_TYPE          instruction_in,
  input  logic                     instruction_en,
  output logic                     instruction_busy,
  output INSTRUCTION_TYPE          weight_instruction,
  output logic                     weight_en,
  input  logic                     weight_busy,
  output INSTRUCTION_TYPE          mmu_instruction,
  output logic                     mmu_en,
  input  logic                     mmu_busy,
  output INSTRUCTION_TYPE          act_instruction,
  output logic                     act_en,
  input  logic                     act_busy,
  output logic                     sync_done,
  output logic                     halted,
`ifdef DISPATCH_PERF_CNT_EN
  output logic                     illegal_opcode,
  output logic [COUNTER_WIDTH-1:0] stall_cycles,
  output logic [COUNTER_WIDTH-1:0] issued_count
`else
  output logic                     illegal_opcode
`endif
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t          state_r;
  logic            hold_valid_r;
  INSTRUCTION_TYPE hold_instr_r;
  instr_class_t    hold_class_s;
  logic            issue_now_s;
  logic            weight_free_s;
  logic            mmu_free_s;
  logic            act_free_s;

  // Full-byte encodings take priority over the class field in the upper bits.
  function automatic instr_class_t decode_class(input logic [OP_CODE_WIDTH-1:0] op);
    instr_class_t cls;
    if (op == 8'h00) begin
      cls = CLS_NOP;
    end else if (op == 8'hFE) begin
      cls = CLS_SYNC;
    end else if (op == 8'hFF) begin
      cls = CLS_HALT;
    end else begin
      case (op[OP_CODE_WIDTH-1:3])
        5'b00001: cls = CLS_WEIGHT;
        5'b00010: cls = CLS_MMU;
        5'b00100: cls = CLS_ACT;
        default:  cls = CLS_ILLEGAL;
      endcase
    end
    return cls;
  endfunction

  // Hazard check for the held instruction against unit occupancy.
  always_comb begin
    // The registered en covers the cycle before a unit can raise busy.
    weight_free_s = !weight_busy && !weight_en;
    mmu_free_s    = !mmu_busy && !mmu_en;
    act_free_s    = !act_busy && !act_en;
    hold_class_s  = decode_class(hold_instr_r.op_code);
    issue_now_s   = 1'b0;
    if (state_r == ST_RUN && hold_valid_r) begin
      case (hold_class_s)
        CLS_WEIGHT: issue_now_s = weight_free_s;
        CLS_MMU:    issue_now_s = mmu_free_s && weight_free_s;
        CLS_ACT:    issue_now_s = act_free_s && mmu_free_s;
        CLS_SYNC,
        CLS_HALT:   issue_now_s = weight_free_s && mmu_free_s && act_free_s;
        default:    issue_now_s = 1'b1;
      endcase
    end else begin
      issue_now_s = 1'b0;
    end
  end

  assign instruction_busy = (hold_valid_r && !issue_now_s) || (state_r == ST_HALTED);

  // Dispatch state machine, hold register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r            <= ST_RUN;
      hold_valid_r       <= 1'b0;
      hold_instr_r       <= '0;
      weight_instruction <= '0;
      mmu_instruction    <= '0;
      act_instruction    <= '0;
      weight_en          <= 1'b0;
      mmu_en             <= 1'b0;
      act_en             <= 1'b0;
      sync_done          <= 1'b0;
      halted             <= 1'b0;
      illegal_opcode     <= 1'b0;
    end else begin
      weight_en <= 1'b0;
      mmu_en    <= 1'b0;
      act_en    <= 1'b0;
      sync_done <= 1'b0;
      case (state_r)
        ST_RUN: begin
          if (instruction_en) begin
            hold_instr_r <= instruction_in;
            hold_valid_r <= 1'b1;
          end else if (issue_now_s) begin
            hold_valid_r <= 1'b0;
          end
          if (issue_now_s) begin
            case (hold_class_s)
              CLS_WEIGHT: begin
                weight_en          <= 1'b1;
                weight_instruction <= hold_instr_r;
              end
              CLS_MMU: begin
                mmu_en          <= 1'b1;
                mmu_instruction <= hold_instr_r;
              end
              CLS_ACT: begin
                act_en          <= 1'b1;
                act_instruction <= hold_instr_r;
              end
              CLS_SYNC: sync_done <= 1'b1;
              CLS_HALT: begin
                // Anything loaded alongside the retiring HALT is dropped.
                state_r      <= ST_HALTED;
                halted       <= 1'b1;
                hold_valid_r <= 1'b0;
              end
              CLS_ILLEGAL: illegal_opcode <= 1'b1;
              default: ;
            endcase
          end
        end
        ST_HALTED: begin
          hold_valid_r <= 1'b0;
          halted       <= 1'b1;
        end
        default: state_r <= ST_RUN;
      endcase
    end
  end

`ifdef DISPATCH_PERF_CNT_EN
  // Saturating stall and issue counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      issued_count <= '0;
    end else begin
      if (hold_valid_r && !issue_now_s && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
      end
      if (issue_now_s && (hold_class_s == CLS_WEIGHT || hold_class_s == CLS_MMU ||
                          hold_class_s == CLS_ACT) && (issued_count != '1)) begin
        issued_count <= issued_count + {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Randomized bench for instruction_dispatcher: queue-based reference model with
// emulated execution units that raise busy after each issue.

module tb_instruction_dispatcher;
  import dispatcher_pkg::*;

  localparam int CW = 32;
  localparam int K_NOP = 0, K_W = 1, K_M = 2, K_A = 3, K_SYNC = 4, K_HALT = 5, K_ILL = 6;

  logic            clk = 1'b0;
  logic            rst;
  INSTRUCTION_TYPE instruction_in;
  logic            instruction_en;
  logic            instruction_busy;
  INSTRUCTION_TYPE weight_instruction, mmu_instruction, act_instruction;
  logic            weight_en, mmu_en, act_en;
  logic            weight_busy, mmu_busy, act_busy;
  logic            sync_done, halted, illegal_opcode;
`ifdef DISPATCH_PERF_CNT_EN
  logic [CW-1:0]   stall_cycles, issued_count;
`endif

  instruction_dispatcher #(.COUNTER_WIDTH(CW)) dut (
    .clk                (clk),
    .rst                (rst),
    .instruction_in     (instruction_in),
    .instruction_en     (instruction_en),
    .instruction_busy   (instruction_busy),
    .weight_instruction (weight_instruction),
    .weight_en          (weight_en),
    .weight_busy        (weight_busy),
    .mmu_instruction    (mmu_instruction),
    .mmu_en             (mmu_en),
    .mmu_busy           (mmu_busy),
    .act_instruction    (act_instruction),
    .act_en             (act_en),
    .act_busy           (act_busy),
    .sync_done          (sync_done),
    .halted             (halted),
`ifdef DISPATCH_PERF_CNT_EN
    .illegal_opcode     (illegal_opcode),
    .stall_cycles       (stall_cycles),
    .issued_count       (issued_count)
`else
    .illegal_opcode     (illegal_opcode)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  INSTRUCTION_TYPE q[$];
  logic            m_en[3];
  INSTRUCTION_TYPE m_instr[3];
  logic            m_sync, m_halted, m_illegal;
  bit              halted_mode;
  int              halt_wait;
  logic [CW-1:0]   m_stall, m_issued;
  int              rem[3], dur[3];
  bit              pend[3];
  bit              busy_v[3];

  function automatic int classify(input logic [7:0] op);
    if (op == 8'hFF) return K_HALT;
    if (op == 8'hFE) return K_SYNC;
    if (op == 8'h00) return K_NOP;
    if (op >= 8'h08 && op <= 8'h0F) return K_W;
    if (op >= 8'h10 && op <= 8'h17) return K_M;
    if (op >= 8'h20 && op <= 8'h27) return K_A;
    return K_ILL;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int u = 0; u < 3; u++) begin
      m_en[u] = 1'b0; m_instr[u] = '0; rem[u] = 0; pend[u] = 1'b0; busy_v[u] = 1'b0;
    end
    m_sync = 1'b0; m_halted = 1'b0; m_illegal = 1'b0;
    halted_mode = 1'b0; halt_wait = 0;
    m_stall = '0; m_issued = '0;
  endtask

  function automatic INSTRUCTION_TYPE rand_instr();
    INSTRUCTION_TYPE ins;
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 25)      ins.op_code = 8'h08 + 8'($urandom_range(0, 7));
    else if (r < 45) ins.op_code = 8'h10 + 8'($urandom_range(0, 7));
    else if (r < 65) ins.op_code = 8'h20 + 8'($urandom_range(0, 7));
    else if (r < 72) ins.op_code = 8'h00;
    else if (r < 80) ins.op_code = 8'hFE;
    else if (r < 95) ins.op_code = 8'($urandom_range(1, 253));
    else             ins.op_code = 8'hFF;
    ins.calc_length    = $urandom;
    ins.acc_address    = 16'($urandom);
    ins.buffer_address = 24'($urandom);
    return ins;
  endfunction

  task automatic check_outputs();
    check_val("weight_en", 128'(weight_en), 128'(m_en[0]));
    check_val("mmu_en", 128'(mmu_en), 128'(m_en[1]));
    check_val("act_en", 128'(act_en), 128'(m_en[2]));
    check_val("weight_instruction", 128'(weight_instruction), 128'(m_instr[0]));
    check_val("mmu_instruction", 128'(mmu_instruction), 128'(m_instr[1]));
    check_val("act_instruction", 128'(act_instruction), 128'(m_instr[2]));
    check_val("sync_done", 128'(sync_done), 128'(m_sync));
    check_val("halted", 128'(halted), 128'(m_halted));
    check_val("illegal_opcode", 128'(illegal_opcode), 128'(m_illegal));
`ifdef DISPATCH_PERF_CNT_EN
    check_val("stall_cycles", 128'(stall_cycles), 128'(m_stall));
    check_val("issued_count", 128'(issued_count), 128'(m_issued));
`endif
  endtask

  initial begin
    bit iss, exp_busy, do_rst, new_halt;
    int cls, d;
    INSTRUCTION_TYPE head;

    rst = 1'b1; instruction_en = 1'b0; instruction_in = '0;
    weight_busy = 1'b0; mmu_busy = 1'b0; act_busy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      check_outputs();
      do_rst = (halted_mode && halt_wait == 0) || ($urandom_range(0, 399) == 0);
      if (do_rst) begin
        rst = 1'b1; instruction_en = 1'b0;
        weight_busy = 1'b0; mmu_busy = 1'b0; act_busy = 1'b0;
        @(posedge clk);
        model_reset();
      end else begin
        rst = 1'b0;
        // Emulated units: busy for a few cycles, starting with or one cycle after en
        for (int u = 0; u < 3; u++) begin
          if (pend[u]) begin
            rem[u] = dur[u]; pend[u] = 1'b0;
          end else if (m_en[u]) begin
            d = int'($urandom_range(1, 6));
            if ($urandom_range(0, 1) == 1) rem[u] = d;
            else begin pend[u] = 1'b1; dur[u] = d; end
          end else if (rem[u] == 0 && $urandom_range(0, 24) == 0) begin
            rem[u] = int'($urandom_range(1, 8));
          end
          busy_v[u] = (rem[u] > 0);
        end
        weight_busy = busy_v[0]; mmu_busy = busy_v[1]; act_busy = busy_v[2];
        #1;

        iss = 1'b0; cls = K_NOP;
        if (!halted_mode && q.size() > 0) begin
          cls = classify(q[0].op_code);
          case (cls)
            K_W:            iss = !busy_v[0] && !m_en[0];
            K_M:            iss = !busy_v[1] && !m_en[1] && !busy_v[0] && !m_en[0];
            K_A:            iss = !busy_v[2] && !m_en[2] && !busy_v[1] && !m_en[1];
            K_SYNC, K_HALT: iss = !busy_v[0] && !m_en[0] && !busy_v[1] && !m_en[1] &&
                                  !busy_v[2] && !m_en[2];
            default:        iss = 1'b1;
          endcase
        end
        exp_busy = (q.size() > 0 && !iss) || halted_mode;
        check_val("instruction_busy", 128'(instruction_busy), 128'(exp_busy));

        if (halted_mode)   instruction_en = ($urandom_range(0, 1) == 1);
        else if (!exp_busy) instruction_en = ($urandom_range(0, 9) < 7);
        else               instruction_en = 1'b0;
        instruction_in = rand_instr();

        // Model state after the coming edge
        for (int u = 0; u < 3; u++) m_en[u] = 1'b0;
        m_sync = 1'b0; new_halt = 1'b0;
        if (q.size() > 0 && !iss && !halted_mode && m_stall != '1) m_stall++;
        if (iss) begin
          head = q.pop_front();
          case (cls)
            K_W:    begin m_en[0] = 1'b1; m_instr[0] = head; end
            K_M:    begin m_en[1] = 1'b1; m_instr[1] = head; end
            K_A:    begin m_en[2] = 1'b1; m_instr[2] = head; end
            K_SYNC: m_sync = 1'b1;
            K_HALT: new_halt = 1'b1;
            K_ILL:  m_illegal = 1'b1;
            default: ;
          endcase
          if ((cls == K_W || cls == K_M || cls == K_A) && m_issued != '1) m_issued++;
        end
        if (instruction_en && !halted_mode) q.push_back(instruction_in);
        if (new_halt) begin
          halted_mode = 1'b1; m_halted = 1'b1; q.delete();
          halt_wait = int'($urandom_range(3, 12));
        end else if (halted_mode && halt_wait > 0) begin
          halt_wait--;
        end
        for (int u = 0; u < 3; u++) if (rem[u] > 0) rem[u]--;
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
